rtc_bcd_field_reg: RTL and testbench

Parametrised BCD time/date field register for the RTC interface. One instance per field: seconds, minutes, hours, day, month or year. Holds the current BCD value, which can be:
- loaded from the RTC read path;
- stepped up/down by the user while editing, with edge-detected single steps and hold-to-auto-repeat;
- advanced by a count tick that emits a carry for cascading fields.
Range limits are parameters, so one block covers 00-59, 00-23, 01-31, 01-12 and 00-99.

---
 rtl/rtc_bcd_field_reg.sv | 113 +++++++++++
 tb/tb_rtc_bcd_field_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rtc_bcd_field_reg.sv
// rtc_bcd_field_reg: BCD time/date field with load, edit stepping with auto-repeat, and tick/carry cascade
module rtc_bcd_field_reg #(
  parameter logic [7:0] MAX_VAL    = 8'h59,
  parameter logic [7:0] MIN_VAL    = 8'h00,
  parameter logic [7:0] RST_VAL    = 8'h00,
  parameter int         REPEAT_DLY = 25000000,
  parameter int         REPEAT_PER = 5000000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       Modificando,
  input  logic       Actualizar,
  input  logic       TICK,
  input  logic [7:0] DATA_in,
  output logic [7:0] DATA_out,
  output logic       CARRY,
  output logic       LOAD_ERR,
  output logic       EDITED
);
  localparam int CW = $clog2(REPEAT_DLY > REPEAT_PER ? REPEAT_DLY : REPEAT_PER) + 1;
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] val_q, val_d, inc_v, dec_v;
  logic carry_q, carry_d, lerr_q, lerr_d, ed_q, ed_d;
  logic dir_q, dir_d, up_q, dn_q, blk_q;
  logic edge_det, held, step, step_up, load_ok;
  logic [8:0] lo_diff, hi_diff;
  assign inc_v = val_q == MAX_VAL ? MIN_VAL :
                 val_q[3:0] == 4'd9 ? {val_q[7:4] + 4'd1, 4'd0} : {val_q[7:4], val_q[3:0] + 4'd1};
  assign dec_v = val_q == MIN_VAL ? MAX_VAL :
                 val_q[3:0] == 4'd0 ? {val_q[7:4] - 4'd1, 4'd9} : {val_q[7:4], val_q[3:0] - 4'd1};
  assign lo_diff = {1'b0, DATA_in} - {1'b0, MIN_VAL};
  assign hi_diff = {1'b0, MAX_VAL} - {1'b0, DATA_in};
  assign load_ok = DATA_in[7:4] <= 4'd9 && DATA_in[3:0] <= 4'd9 && !lo_diff[8] && !hi_diff[8];
  // blk_q suppresses a false edge when a button is still held across reset release
  assign edge_det = !blk_q && ((UP && !up_q) || (!UP && DOWN && !dn_q));
  assign held = dir_q ? UP : DOWN;
  assign step_up = edge_det ? UP : dir_q;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    step = 1'b0;
    if (!Modificando) begin
      st_d = IDLE;
      cnt_d = '0;
    end else if (edge_det) begin
      step = 1'b1;
      dir_d = UP;
      cnt_d = '0;
      st_d = HOLD;
    end else if (st_q == IDLE || !held) begin
      st_d = IDLE;
      cnt_d = '0;
    end else if (st_q == HOLD) begin
      step = cnt_q == CW'(REPEAT_DLY - 2);
      cnt_d = step ? '0 : cnt_q + 1'b1;
      st_d = step ? REPEAT : HOLD;
    end else begin
      step = cnt_q == CW'(REPEAT_PER - 1);
      cnt_d = step ? '0 : cnt_q + 1'b1;
    end
  end
  always_comb begin
    val_d = val_q;
    ed_d = ed_q;
    carry_d = 1'b0;
    lerr_d = 1'b0;
    if (step) begin
      val_d = step_up ? inc_v : dec_v;
      ed_d = 1'b1;
    end else if (!Modificando && Actualizar) begin
      val_d = load_ok ? DATA_in : val_q;
      ed_d = load_ok ? 1'b0 : ed_q;
      lerr_d = !load_ok;
    end else if (!Modificando && TICK) begin
      val_d = inc_v;
      carry_d = val_q == MAX_VAL;
    end
  end
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      st_q <= IDLE;
      cnt_q <= '0;
      val_q <= RST_VAL;
      carry_q <= 1'b0;
      lerr_q <= 1'b0;
      ed_q <= 1'b0;
      dir_q <= 1'b0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
      blk_q <= 1'b1;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      carry_q <= carry_d;
      lerr_q <= lerr_d;
      ed_q <= ed_d;
      dir_q <= dir_d;
      up_q <= UP;
      dn_q <= DOWN;
      blk_q <= blk_q && (UP || DOWN);
    end
  end
  assign DATA_out = val_q;
  assign CARRY = carry_q;
  assign LOAD_ERR = lerr_q;
  assign EDITED = ed_q;
endmodule

// File: tb/tb_rtc_bcd_field_reg.sv
// tb_rtc_bcd_field_reg: directed checks of stepping, auto-repeat, cascade, load limits and reset
module tb_rtc_bcd_field_reg;
  logic clk = 1'b0, rst_n = 1'b0;
  logic up = 1'b0, dn = 1'b0, mod = 1'b0, upd = 1'b0, tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic carry, lerr, edited;
  logic zero = 1'b0, upd2 = 1'b0, tick2 = 1'b0;
  logic [7:0] din2 = 8'h00;
  logic [7:0] dout2;
  logic carry2, lerr2, edited2;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  rtc_bcd_field_reg #(.MAX_VAL(8'h59), .MIN_VAL(8'h00), .RST_VAL(8'h00), .REPEAT_DLY(4), .REPEAT_PER(2)) dut (
    .CLK(clk), .RST_n(rst_n), .UP(up), .DOWN(dn), .Modificando(mod), .Actualizar(upd), .TICK(tick),
    .DATA_in(din), .DATA_out(dout), .CARRY(carry), .LOAD_ERR(lerr), .EDITED(edited));
  rtc_bcd_field_reg #(.MAX_VAL(8'h12), .MIN_VAL(8'h01), .RST_VAL(8'h01), .REPEAT_DLY(4), .REPEAT_PER(2)) dut2 (
    .CLK(clk), .RST_n(rst_n), .UP(zero), .DOWN(zero), .Modificando(zero), .Actualizar(upd2), .TICK(tick2),
    .DATA_in(din2), .DATA_out(dout2), .CARRY(carry2), .LOAD_ERR(lerr2), .EDITED(edited2));
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic load1(input logic [7:0] v);
    mod = 1'b0; upd = 1'b1; din = v;
    cyc();
    upd = 1'b0;
  endtask
  task automatic pulse(input logic u, input logic d);
    up = u; dn = d;
    cyc();
    up = 1'b0; dn = 1'b0;
    cyc();
  endtask
  initial begin
    logic [7:0] rep_exp [10];
    rep_exp = '{8'h58, 8'h58, 8'h58, 8'h59, 8'h59, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02};
    up = 1'b1;
    cyc(3);
    chk("rst_val", dout, 8'h00);
    chk("rst_carry", {7'd0, carry}, 8'h00);
    chk("rst_edited", {7'd0, edited}, 8'h00);
    rst_n = 1'b1; mod = 1'b1;
    cyc(2);
    chk("rst_release_no_step", dout, 8'h00);
    up = 1'b0;
    cyc();
    up = 1'b1;
    cyc();
    chk("rst_rearm_step", dout, 8'h01);
    up = 1'b0;
    cyc();
    load1(8'h09);
    chk("load_09", dout, 8'h09);
    chk("load_clears_edited", {7'd0, edited}, 8'h00);
    mod = 1'b1;
    pulse(1'b1, 1'b0);
    chk("inc_09", dout, 8'h10);
    chk("edited_set", {7'd0, edited}, 8'h01);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("dec_10_twice", dout, 8'h08);
    load1(8'h00);
    mod = 1'b1;
    pulse(1'b0, 1'b1);
    chk("dec_wrap", dout, 8'h59);
    load1(8'h57);
    mod = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("repeat_c%0d", i + 1), dout, rep_exp[i]);
    end
    up = 1'b0;
    cyc(3);
    chk("repeat_release", dout, 8'h02);
    pulse(1'b1, 1'b1);
    chk("both_up_wins", dout, 8'h03);
    load1(8'h58);
    tick = 1'b1;
    cyc();
    chk("tick_59", dout, 8'h59);
    chk("tick_59_carry", {7'd0, carry}, 8'h00);
    cyc();
    chk("tick_wrap", dout, 8'h00);
    chk("tick_wrap_carry", {7'd0, carry}, 8'h01);
    tick = 1'b0;
    cyc();
    chk("carry_one_cycle", {7'd0, carry}, 8'h00);
    mod = 1'b1; tick = 1'b1;
    cyc(2);
    chk("tick_frozen", dout, 8'h00);
    chk("tick_frozen_carry", {7'd0, carry}, 8'h00);
    mod = 1'b0; upd = 1'b1; din = 8'h30; dn = 1'b0;
    cyc();
    chk("load_beats_tick", dout, 8'h30);
    upd = 1'b0; tick = 1'b0;
    upd2 = 1'b1; din2 = 8'h13;
    cyc();
    chk("ld2_13_err", {7'd0, lerr2}, 8'h01);
    chk("ld2_13_kept", dout2, 8'h01);
    upd2 = 1'b0;
    cyc();
    chk("ld2_err_pulse", {7'd0, lerr2}, 8'h00);
    upd2 = 1'b1; din2 = 8'h1A;
    cyc();
    chk("ld2_1A_err", {7'd0, lerr2}, 8'h01);
    din2 = 8'h00;
    cyc();
    chk("ld2_00_err", {7'd0, lerr2}, 8'h01);
    chk("ld2_00_kept", dout2, 8'h01);
    din2 = 8'h12;
    cyc();
    upd2 = 1'b0;
    chk("ld2_12_ok", dout2, 8'h12);
    chk("ld2_12_noerr", {7'd0, lerr2}, 8'h00);
    chk("ld2_edited", {7'd0, edited2}, 8'h00);
    tick2 = 1'b1;
    cyc();
    tick2 = 1'b0;
    chk("tick2_wrap", dout2, 8'h01);
    chk("tick2_carry", {7'd0, carry2}, 8'h01);
    mod = 1'b1; up = 1'b1;
    cyc(6);
    chk("pre_reset_val", dout, 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_val", dout, 8'h00);
    chk("async_reset_edited", {7'd0, edited}, 8'h00);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    chk("no_step_after_reset", dout, 8'h00);
    up = 1'b0;
    cyc();
    up = 1'b1;
    cyc(2);
    chk("idle_after_reset", dout, 8'h01);
    up = 1'b0;
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
